mem_arbiter: RTL and testbench

//   Two-master arbiter for the shared 8-bit RAM port. Master 0 is the CPU; master 1 is a

---
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for a shared RAM port.
// Supports bounded locked bursts and tags read data back to its issuer.
module mem_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 8,
  parameter int RD_LAT   = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_we,
  output logic          m0_gnt,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_rvalid,
  input  logic          m1_req,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_we,
  output logic          m1_gnt,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_rvalid,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_di,
  output logic          ram_we,
  input  logic [DW-1:0] ram_do,
  output logic          owner
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          last_q, last_d;
  logic          owner_q, owner_d;

  logic          gnt0, gnt1, pick1;
  logic          beat, gid, glock;
  logic          at_max;

  logic [RD_LAT-1:0] tv_q;
  logic [RD_LAT-1:0] tid_q;

  assign at_max = (hold_q >= HOLD_MAX);

  // State, hold counter, round-robin pointer and debug owner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      owner_q <= owner_d;
    end
  end

  // Next state: every beat re-evaluates lock ownership
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    last_d  = last_q;
    owner_d = owner_q;
    beat    = gnt0 | gnt1;
    gid     = gnt1;
    glock   = gnt1 ? m1_lock : m0_lock;
    if (!beat) begin
      state_d = IDLE;
    end else begin
      last_d  = gid;
      owner_d = gid;
      if (glock) begin
        state_d = gid ? LOCK1 : LOCK0;
        if (state_q == (gid ? LOCK1 : LOCK0))
          hold_d = at_max ? hold_q : hold_q + HW'(1);
        else
          hold_d = HW'(1);
      end else begin
        state_d = IDLE;
      end
    end
  end

  // Grant decision and RAM mux, combinational in the beat cycle
  always_comb begin
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    pick1 = 1'b0;
    unique case (state_q)
      LOCK0:   pick1 = at_max;
      LOCK1:   pick1 = ~at_max;
      default: pick1 = ~last_q;
    endcase
    if (rst_n) begin
      unique case (1'b1)
        (m0_req & ~m1_req): gnt0 = 1'b1;
        (m1_req & ~m0_req): gnt1 = 1'b1;
        (m0_req & m1_req): begin
          gnt0 = ~pick1;
          gnt1 = pick1;
        end
        default: ;
      endcase
    end
    ram_addr = '0;
    ram_di   = '0;
    ram_we   = 1'b0;
    if (gnt0) begin
      ram_addr = m0_addr;
      ram_di   = m0_wdata;
      ram_we   = m0_we;
    end else if (gnt1) begin
      ram_addr = m1_addr;
      ram_di   = m1_wdata;
      ram_we   = m1_we;
    end
  end

  // Read tag pipe aligned with the RAM read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tv_q  <= '0;
      tid_q <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        tv_q[i]  <= tv_q[i-1];
        tid_q[i] <= tid_q[i-1];
      end
      tv_q[0]  <= beat & ~ram_we;
      tid_q[0] <= gid;
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rdata  = ram_do;
  assign m1_rdata  = ram_do;
  assign m0_rvalid = tv_q[RD_LAT-1] & ~tid_q[RD_LAT-1];
  assign m1_rvalid = tv_q[RD_LAT-1] & tid_q[RD_LAT-1];
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic
// against a rule-level arbitration and RAM model.
module tb_mem_arbiter;

  localparam int AW       = 16;
  localparam int DW       = 8;
  localparam int MAX_HOLD = 8;
  localparam int RD_LAT   = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req, m0_lock, m0_we, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_lock, m1_we, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di, ram_do;
  logic          ram_we, owner;

  mem_arbiter #(
    .AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_we(m0_we), .m0_gnt(m0_gnt),
    .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_we(m1_we), .m1_gnt(m1_gnt),
    .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .ram_addr(ram_addr), .ram_di(ram_di), .ram_we(ram_we),
    .ram_do(ram_do), .owner(owner)
  );

  always #5 clk = ~clk;

  // RAM with one-cycle registered read, preloaded on its first clock
  logic [DW-1:0] mem [0:65535];
  logic          loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 8'(i * 37 + 5);
      loaded <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_di;
    end
    ram_do <= mem[ram_addr];
  end

  typedef struct {
    bit            v;
    int            id;
    logic [DW-1:0] data;
  } tag_t;

  logic [DW-1:0] ref_mem [0:65535];
  tag_t pq[$];
  int   mlk, mcnt, mlast, mown;
  int   checks = 0;
  int   failures = 0;
  int   obs_g;
  logic obs_rv1;
  logic [DW-1:0] obs_rd1;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    tag_t z;
    z.v = 1'b0; z.id = 0; z.data = '0;
    mlk = -1; mcnt = 0; mlast = 1; mown = 0;
    pq.delete();
    for (int i = 0; i < RD_LAT; i++) pq.push_back(z);
  endtask

  // Arbitration rules: sole requester wins; tie uses lock or round robin
  function automatic int pick(bit r0, bit r1);
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    if (!r0) return -1;
    if (mlk < 0) return 1 - mlast;
    if (mcnt < MAX_HOLD) return mlk;
    return 1 - mlk;
  endfunction

  task automatic step(
    input bit r0, input bit l0, input bit w0,
    input logic [AW-1:0] a0, input logic [DW-1:0] d0,
    input bit r1, input bit l1, input bit w1,
    input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    int g;
    bit gl, gw;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    tag_t e, n;
    @(negedge clk);
    m0_req = r0; m0_lock = l0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_lock = l1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    #1;
    g  = pick(r0, r1);
    gl = (g == 1) ? l1 : l0;
    gw = (g == 1) ? w1 : w0;
    ga = (g == 1) ? a1 : a0;
    gd = (g == 1) ? d1 : d0;
    if (g < 0) begin
      gl = 1'b0; gw = 1'b0; ga = '0; gd = '0;
    end
    e = pq.pop_front();
    chk("gnt0", int'(m0_gnt), int'(g == 0));
    chk("gnt1", int'(m1_gnt), int'(g == 1));
    chk("ram_we", int'(ram_we), int'(gw));
    chk("ram_addr", int'(ram_addr), int'(ga));
    chk("ram_di", int'(ram_di), int'(gd));
    chk("rvalid0", int'(m0_rvalid), int'(e.v && e.id == 0));
    chk("rvalid1", int'(m1_rvalid), int'(e.v && e.id == 1));
    if (e.v)
      chk("rdata", int'(e.id == 0 ? m0_rdata : m1_rdata), int'(e.data));
    chk("owner", int'(owner), mown);
    obs_g   = m1_gnt ? 1 : (m0_gnt ? 0 : -1);
    obs_rv1 = m1_rvalid;
    obs_rd1 = m1_rdata;
    n.v    = (g >= 0) && !gw;
    n.id   = (g < 0) ? 0 : g;
    n.data = ref_mem[ga];
    pq.push_back(n);
    if (g >= 0) begin
      if (gw) ref_mem[ga] = gd;
      mlast = g;
      mown  = g;
      if (gl) begin
        if (mlk == g) mcnt = (mcnt < MAX_HOLD) ? mcnt + 1 : mcnt;
        else mcnt = 1;
        mlk = g;
      end else begin
        mlk = -1;
      end
    end else begin
      mlk = -1;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
  endtask

  // Reset with both masters hammering: nothing may leak through
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m0_req = 1; m0_we = 1; m0_addr = 16'h0055; m0_wdata = 8'h3C;
    m1_req = 1; m1_we = 1; m1_addr = 16'h00AA; m1_wdata = 8'hC3;
    #1;
    chk("rst_gnt0", int'(m0_gnt), 0);
    chk("rst_gnt1", int'(m1_gnt), 0);
    chk("rst_we", int'(ram_we), 0);
    chk("rst_addr", int'(ram_addr), 0);
    chk("rst_di", int'(ram_di), 0);
    chk("rst_rv0", int'(m0_rvalid), 0);
    chk("rst_rv1", int'(m1_rvalid), 0);
    chk("rst_owner", int'(owner), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int exp_g;
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'(i * 37 + 5);
    rst_n = 1'b0;
    m0_req = 0; m0_lock = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_lock = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    do_reset();

    // single m0 read, data returns one cycle later
    step(1, 0, 0, 16'h0010, '0, 0, 0, 0, '0, '0);
    chk("t1_gnt", obs_g, 0);
    idle();

    // continuous contention without lock alternates from m0
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, AW'(i), '0, 1, 0, 0, AW'(i + 32), '0);
      chk("t2_alt", obs_g, i % 2);
    end
    idle();

    // m1 locked write burst, m0 forced in after MAX_HOLD beats
    do_reset();
    step(1, 0, 0, 16'h0003, '0, 0, 0, 0, '0, '0);
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, AW'(i), '0, 1, 1, 1, AW'(16'h0200 + i), DW'(i));
      exp_g = (i == 8 || i == 17) ? 0 : 1;
      chk("t3_burst", obs_g, exp_g);
    end
    idle();

    // m0 lock for three beats then release; m1 gets the 5th cycle
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1, (i < 3), 0, AW'(i), '0, 1, 0, 0, AW'(i + 64), '0);
      exp_g = (i == 4) ? 1 : 0;
      chk("t4_lock", obs_g, exp_g);
    end
    idle();

    // m0 write then m1 read of the same address
    step(1, 0, 1, 16'h1234, 8'hA5, 0, 0, 0, '0, '0);
    step(0, 0, 0, '0, '0, 1, 0, 0, 16'h1234, '0);
    idle();
    chk("t5_rv", int'(obs_rv1), 1);
    chk("t5_rdata", int'(obs_rd1), 8'hA5);

    // reset right after an m1 read drops the read and re-arms m0 priority
    idle();
    step(0, 0, 0, '0, '0, 1, 0, 0, 16'h0040, '0);
    do_reset();
    step(1, 0, 0, 16'h0041, '0, 1, 0, 0, 16'h0042, '0);
    chk("t6_tie", obs_g, 0);
    idle();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      step($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
           AW'($urandom_range(0, 15)), DW'($urandom),
           $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
           AW'($urandom_range(0, 15)), DW'($urandom));
    end
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
